// File: rtl/ysyx_22040365_ex_mdu.sv
// ysyx_22040365_ex_mdu -- iterative RV64M multiply/divide unit for the EX stage.
//
// One operation in flight. A normal operation is accepted in IDLE and runs
// 64 radix-2 steps in CALC: shift-add for multiply, restoring shift-subtract
// for divide, both on operand magnitudes. It then presents the result for
// one cycle in DONE. Divide-by-zero and signed divide overflow skip CALC and
// go straight to DONE.
//
// Ports
//   clk, rst          rising-edge clock, async active-low reset
//   valid_in          ID/EX holds an M-extension instruction
//   flush             synchronous kill of any in-flight operation
//   op                RV funct3 (MUL..REMU)
//   is_word           RV64 *W variant
//   src1, src2        forwarded rs1 / rs2
//   rd_addr_in        destination register
//   busy              combinational stall request to ID/EX and upstream
//   result_valid      one-cycle result pulse
//   result            64-bit result, held until the next result
//   rd_addr_out       destination register of the presented result
module ysyx_22040365_ex_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        flush,
  input  logic [2:0]  op,
  input  logic        is_word,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic [4:0]  rd_addr_in,
  output logic        busy,
  output logic        result_valid,
  output logic [63:0] result,
  output logic [4:0]  rd_addr_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  cnt;
  logic [63:0] hi;      // product high half / partial remainder
  logic [63:0] lo;      // multiplier (shifted out) / quotient (shifted in)
  logic [63:0] dvs;     // multiplicand / divisor magnitude
  logic [2:0]  op_q;
  logic        word_q;
  logic        neg_q;   // negate product or quotient
  logic        rneg_q;  // negate remainder
  logic [4:0]  rd_q;

  // ---------------------------------------------------------------- operand prep
  logic        is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, a_mag, b_mag;
  logic        div0, ovf, special, accept;
  logic [63:0] spec_res, spec_res_w;

  always_comb begin
    is_div = op[2];
    // MULHSU treats only src1 as signed; MUL sign handling does not affect the low half.
    a_sgn  = is_div ? ~op[0] : (op[1:0] != 2'd3);
    b_sgn  = is_div ? ~op[0] : ~op[1];
    a_ext  = is_word ? {{32{a_sgn & src1[31]}}, src1[31:0]} : src1;
    b_ext  = is_word ? {{32{b_sgn & src2[31]}}, src2[31:0]} : src2;
    a_neg  = a_sgn & a_ext[63];
    b_neg  = b_sgn & b_ext[63];
    a_mag  = a_neg ? -a_ext : a_ext;
    b_mag  = b_neg ? -b_ext : b_ext;

    div0    = is_div & (b_ext == 64'd0);
    // Most-negative value at the operative width; word operands are already sign-extended.
    ovf     = is_div & ~op[0] & (b_ext == {64{1'b1}}) &
              (a_ext == (is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    special = div0 | ovf;

    // div0: q = all ones, r = dividend; overflow: q = dividend, r = 0.
    if (op[1]) spec_res = div0 ? a_ext : 64'd0;
    else       spec_res = div0 ? {64{1'b1}} : a_ext;
    spec_res_w = is_word ? {{32{spec_res[31]}}, spec_res[31:0]} : spec_res;

    accept = (state == IDLE) & valid_in & ~flush;
  end

  assign busy = rst & (accept | (state == CALC));

  // ---------------------------------------------------------------- one iteration
  logic [64:0]  msum, rsh, dif;
  logic         ge;
  logic [63:0]  step_hi, step_lo, q_s, r_s, calc_res, calc_raw;
  logic [127:0] prod, prod_s;

  always_comb begin
    // Shift-add: conditionally add multiplicand to the high half, shift the pair right.
    msum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : 65'd0);
    // Restoring divide: shift the next dividend bit into the remainder, try a subtract.
    // The shifted remainder is < 2*divisor, so bit 64 of the difference is the borrow.
    rsh  = {hi, lo[63]};
    dif  = rsh - {1'b0, dvs};
    ge   = ~dif[64];
    if (op_q[2]) begin
      step_hi = ge ? dif[63:0] : rsh[63:0];
      step_lo = {lo[62:0], ge};
    end else begin
      step_hi = msum[64:1];
      step_lo = {msum[0], lo[63:1]};
    end

    prod   = {step_hi, step_lo};
    prod_s = neg_q ? -prod : prod;
    q_s    = neg_q  ? -step_lo : step_lo;
    r_s    = rneg_q ? -step_hi : step_hi;
    if (op_q[2])            calc_raw = op_q[1] ? r_s : q_s;
    else if (op_q == 3'd0)  calc_raw = prod_s[63:0];
    else                    calc_raw = prod_s[127:64];

    if (!word_q)                          calc_res = calc_raw;
    else if (!op_q[2] && op_q[1:0] != 0)  calc_res = 64'd0;   // no MULHW and friends
    else                                  calc_res = {{32{calc_raw[31]}}, calc_raw[31:0]};
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (valid_in) state_nxt = special ? DONE : CALC;
        CALC:    if (cnt == 7'd63) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= 7'd0;
      hi           <= 64'd0;
      lo           <= 64'd0;
      dvs          <= 64'd0;
      op_q         <= 3'd0;
      word_q       <= 1'b0;
      neg_q        <= 1'b0;
      rneg_q       <= 1'b0;
      rd_q         <= 5'd0;
      result_valid <= 1'b0;
      result       <= 64'd0;
      rd_addr_out  <= 5'd0;
    end else begin
      result_valid <= (state_nxt == DONE);
      if (accept) begin
        cnt    <= 7'd0;
        hi     <= 64'd0;
        lo     <= a_mag;
        dvs    <= b_mag;
        op_q   <= op;
        word_q <= is_word;
        neg_q  <= a_neg ^ b_neg;
        rneg_q <= a_neg;
        rd_q   <= rd_addr_in;
      end else if (state == CALC) begin
        cnt <= cnt + 7'd1;
        hi  <= step_hi;
        lo  <= step_lo;
      end
      // Output registers only move when a result is presented.
      if (state_nxt == DONE) begin
        result      <= (state == IDLE) ? spec_res_w : calc_res;
        rd_addr_out <= (state == IDLE) ? rd_addr_in : rd_q;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040365_ex_mdu.sv
// Scoreboard bench for ysyx_22040365_ex_mdu: the stimulus process pushes the
// expected result, destination and completion cycle; a negedge monitor pops
// and compares whenever result_valid is seen.
module tb_ysyx_22040365_ex_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        is_word = 1'b0;
  logic [63:0] src1 = 64'd0;
  logic [63:0] src2 = 64'd0;
  logic [4:0]  rd_addr_in = 5'd0;
  logic        busy;
  logic        result_valid;
  logic [63:0] result;
  logic [4:0]  rd_addr_out;

  ysyx_22040365_ex_mdu dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .op(op),
    .is_word(is_word), .src1(src1), .src2(src2), .rd_addr_in(rd_addr_in),
    .busy(busy), .result_valid(result_valid), .result(result),
    .rd_addr_out(rd_addr_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst && result_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got result %h rd %0d with nothing expected (cycle %0d)",
                 result, rd_addr_out, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("rd_addr_out", 64'(rd_addr_out), 64'(e.rd));
        chk("valid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Drive one operation for one cycle starting just after a rising edge.
  // On return the time is #1 after the edge following the accept cycle.
  task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp,
                       input int lat, input bit push, output int t);
    @(posedge clk); #1;
    op = o; is_word = w; src1 = a; src2 = b; rd_addr_in = rd; valid_in = 1'b1;
    t = cyc;
    if (push) q.push_back('{exp, rd, cyc + lat});
    #1;
    chk("busy_accept", 64'(busy), 64'd1);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic run(input logic [2:0] o, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp,
                     input int lat);
    int t;
    issue(o, w, a, b, rd, exp, lat, 1'b1, t);
    wait_drain();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : stim
    int t, bad;
    // Reset state
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    valid_in = 1'b1;
    #1;
    chk("reset_busy_valid", 64'(busy), 64'd0);
    valid_in = 1'b0;
    chk("reset_result", result, 64'd0);
    chk("reset_valid", 64'(result_valid), 64'd0);
    chk("reset_rd", 64'(rd_addr_out), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // MUL 7 * -3 with busy profile T..T+65
    issue(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b1, t);
    bad = 0;
    for (int i = 1; i <= 64; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (busy !== 1'b1) bad++;
    end
    chk("busy_calc_low_count", 64'(bad), 64'd0);
    @(posedge clk); #1;
    chk("busy_done", 64'(busy), 64'd0);
    wait_drain();

    run(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65); // MULHU
    run(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65); // MULHSU
    run(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 64'd0, 65);                  // MULH -1*-1
    run(3'd0, 1'b1, 64'h0000_0001_0000_0003, 64'd5, 5'd5, 64'd15, 65);                                  // MULW
    run(3'd1, 1'b1, 64'd5, 64'd7, 5'd6, 64'd0, 65);                                                     // reserved
    run(3'd5, 1'b0, 64'd100, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1);                                  // DIVU /0
    run(3'd6, 1'b0, 64'd100, 64'd0, 5'd8, 64'd100, 1);                                                  // REM /0
    run(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'h8000_0000_0000_0000, 1); // DIV ovf
    run(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'hFFFF_FFFF_8000_0000, 1); // DIVW ovf
    run(3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 65);               // REMW
    run(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFD, 65);               // DIV -7/2
    run(3'd7, 1'b0, 64'd100, 64'd7, 5'd14, 64'd2, 65);                                                  // REMU
    run(3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd15, 64'h0000_0000_7FFF_FFFC, 65);               // DIVUW

    // Flush a DIV at T+30, new MUL accepted at T+31 completes at T+96
    issue(3'd4, 1'b0, 64'd1000, 64'd7, 5'd16, 64'd0, 65, 1'b0, t);
    repeat (29) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_cycle", 64'(cyc), 64'(t + 31));
    op = 3'd0; is_word = 1'b0; src1 = 64'd3; src2 = 64'd4; rd_addr_in = 5'd17; valid_in = 1'b1;
    q.push_back('{64'd12, 5'd17, t + 96});
    @(posedge clk); #1;
    valid_in = 1'b0;
    wait_drain();

    // Reset mid-CALC, between clock edges
    issue(3'd0, 1'b0, 64'd12345, 64'd678, 5'd18, 64'd0, 65, 1'b0, t);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    valid_in = 1'b1;
    #1;
    chk("midrst_result", result, 64'd0);
    chk("midrst_rd", 64'(rd_addr_out), 64'd0);
    chk("midrst_valid", 64'(result_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 valid_in = 1'b0;
    rst = 1'b1;
    run(3'd5, 1'b0, 64'd9, 64'd2, 5'd19, 64'd4, 65);                                                    // DIVU 9/2

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
